// File: rtl/sht10_responder_pkg.sv
// Shared constants for the SHT10 sensor responder: FSM encoding, command set and CRC polynomial.
package sht10_responder_pkg;

    localparam logic [3:0] ST_IDLE    = 4'd0;
    localparam logic [3:0] ST_RX_CMD  = 4'd1;
    localparam logic [3:0] ST_CMD_ACK = 4'd2;
    localparam logic [3:0] ST_MEASURE = 4'd3;
    localparam logic [3:0] ST_TX_MSB  = 4'd4;
    localparam logic [3:0] ST_ACK1    = 4'd5;
    localparam logic [3:0] ST_TX_LSB  = 4'd6;
    localparam logic [3:0] ST_ACK2    = 4'd7;
    localparam logic [3:0] ST_TX_CRC  = 4'd8;
    localparam logic [3:0] ST_ACK3    = 4'd9;

    localparam logic [2:0] SHT_ADDR = 3'b000;
    localparam logic [4:0] CMD_TEMP = 5'b00011;
    localparam logic [4:0] CMD_RH   = 5'b00101;
    localparam logic [7:0] CRC_POLY = 8'h31;

    function automatic logic [7:0] reverse8(input logic [7:0] v);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = v[7-i];
        return r;
    endfunction

    function automatic logic cmd_supported(input logic [7:0] b);
        return (b[7:5] == SHT_ADDR) && ((b[4:0] == CMD_TEMP) || (b[4:0] == CMD_RH));
    endfunction

endpackage

// File: rtl/sht10_crc8.sv
// Serial MSB-first CRC-8 (x^8+x^5+x^4+1), one bit per shift_en, cleared to zero.
module sht10_crc8
    import sht10_responder_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic       clear,
    input  logic       shift_en,
    input  logic       data_in,
    output logic [7:0] crc
);

    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            crc <= 8'h00;
        else if (clear)
            crc <= 8'h00;
        else if (shift_en)
            crc <= {crc[6:0], 1'b0} ^ (((data_in ^ crc[7]) == 1'b1) ? CRC_POLY : 8'h00);
    end

endmodule

// File: rtl/sht10_responder.sv
// SHT10-compatible sensor responder: receives a command over SCK/SDA, waits a measurement
// time, then returns a 16-bit sample and CRC with open-drain signalling.
module sht10_responder
    import sht10_responder_pkg::*;
#(
    parameter int MEAS_CYCLES = 100000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        SCK,
    inout  wire         SDA,
    input  logic [13:0] temp_value,
    input  logic [11:0] rh_value,
    output logic        busy,
    output logic        cmd_valid,
    output logic [4:0]  cmd_code,
    output logic        cmd_error
);

    localparam int CW = (MEAS_CYCLES > 1) ? $clog2(MEAS_CYCLES) : 1;
    localparam logic [CW-1:0] MEAS_LAST = CW'(MEAS_CYCLES - 1);

    logic sck_s1, sck_s2, sck_q;
    logic sda_s1, sda_s2, sda_q;
    logic sck_rise, sck_fall, sda_fall_h, sda_rise_h;
    logic [1:0] start_phase;
    logic start_det;

    logic [3:0]    state;
    logic [3:0]    bit_cnt;
    logic [7:0]    rx_byte;
    logic [15:0]   tx_shift;
    logic [15:0]   sample;
    logic [CW-1:0] meas_cnt;
    logic          sda_low;
    logic          crc_shift, crc_bit;
    logic [7:0]    crc, crc_rev;

    // Synchronizers idle high to match the pulled-up bus, so reset never looks like an edge into a start.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sck_s1 <= 1'b1; sck_s2 <= 1'b1; sck_q <= 1'b1;
            sda_s1 <= 1'b1; sda_s2 <= 1'b1; sda_q <= 1'b1;
        end else begin
            sck_s1 <= SCK;    sck_s2 <= sck_s1; sck_q <= sck_s2;
            sda_s1 <= SDA;    sda_s2 <= sda_s1; sda_q <= sda_s2;
        end
    end

    assign sck_rise   = sck_s2 & ~sck_q;
    assign sck_fall   = ~sck_s2 & sck_q;
    assign sda_fall_h = ~sda_s2 & sda_q & sck_s2;
    assign sda_rise_h = sda_s2 & ~sda_q & sck_s2;
    assign start_det  = (start_phase == 2'd3) && sda_rise_h;

    // Start phases: 1 = SDA fell with SCK high, 2 = SCK then fell, 3 = SCK rose again with SDA still low.
    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            start_phase <= 2'd0;
        else if (sda_fall_h)
            start_phase <= 2'd1;
        else begin
            case (start_phase)
                2'd1: if (sck_fall) start_phase <= 2'd2;
                      else if (sda_rise_h) start_phase <= 2'd0;
                2'd2: if (sck_rise) start_phase <= sda_s2 ? 2'd0 : 2'd3;
                2'd3: if (sda_rise_h || sck_fall) start_phase <= 2'd0;
                default: start_phase <= 2'd0;
            endcase
        end
    end

    assign sample  = (cmd_code == CMD_RH) ? {4'b0000, rh_value} : {2'b00, temp_value};
    assign crc_rev = reverse8(crc);
    assign busy    = (state != ST_IDLE);

    always_comb begin
        crc_shift = 1'b0;
        crc_bit   = 1'b0;
        if (state == ST_RX_CMD && sck_rise && bit_cnt < 4'd8) begin
            crc_shift = 1'b1;
            crc_bit   = sda_s2;
        end else if ((state == ST_TX_MSB || state == ST_TX_LSB) && sck_fall) begin
            crc_shift = 1'b1;
            crc_bit   = tx_shift[15];
        end
    end

    sht10_crc8 crc_unit (
        .clock    (clock),
        .reset    (reset),
        .clear    (start_det),
        .shift_en (crc_shift),
        .data_in  (crc_bit),
        .crc      (crc)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            bit_cnt   <= 4'd0;
            rx_byte   <= 8'h00;
            tx_shift  <= 16'h0000;
            meas_cnt  <= '0;
            sda_low   <= 1'b0;
            cmd_valid <= 1'b0;
            cmd_error <= 1'b0;
            cmd_code  <= 5'b00000;
        end else begin
            cmd_valid <= 1'b0;
            cmd_error <= 1'b0;
            if (start_det) begin
                state   <= ST_RX_CMD;
                bit_cnt <= 4'd0;
                sda_low <= 1'b0;
            end else begin
                case (state)
                    ST_RX_CMD: begin
                        if (sck_rise && bit_cnt < 4'd8) begin
                            rx_byte <= {rx_byte[6:0], sda_s2};
                            bit_cnt <= bit_cnt + 4'd1;
                        end else if (sck_fall && bit_cnt == 4'd8) begin
                            bit_cnt <= 4'd0;
                            if (cmd_supported(rx_byte)) begin
                                state     <= ST_CMD_ACK;
                                sda_low   <= 1'b1;
                                cmd_code  <= rx_byte[4:0];
                                cmd_valid <= 1'b1;
                            end else begin
                                state     <= ST_IDLE;
                                cmd_error <= 1'b1;
                            end
                        end
                    end
                    ST_CMD_ACK: begin
                        if (sck_fall) begin
                            sda_low  <= 1'b0;
                            meas_cnt <= '0;
                            state    <= ST_MEASURE;
                        end
                    end
                    ST_MEASURE: begin
                        if (meas_cnt == MEAS_LAST) begin
                            tx_shift <= sample;
                            sda_low  <= ~sample[15];
                            bit_cnt  <= 4'd0;
                            state    <= ST_TX_MSB;
                        end else begin
                            meas_cnt <= meas_cnt + 1'b1;
                        end
                    end
                    ST_TX_MSB, ST_TX_LSB, ST_TX_CRC: begin
                        if (sck_fall) begin
                            tx_shift <= {tx_shift[14:0], 1'b0};
                            if (bit_cnt == 4'd7) begin
                                bit_cnt <= 4'd0;
                                sda_low <= 1'b0;
                                state   <= (state == ST_TX_MSB) ? ST_ACK1 :
                                           (state == ST_TX_LSB) ? ST_ACK2 : ST_ACK3;
                            end else begin
                                bit_cnt <= bit_cnt + 4'd1;
                                sda_low <= ~tx_shift[14];
                            end
                        end
                    end
                    // A high acknowledge ends the transfer at once; a low one lets the next byte start on the fall.
                    ST_ACK1: begin
                        if (sck_rise && sda_s2)
                            state <= ST_IDLE;
                        else if (sck_fall) begin
                            state   <= ST_TX_LSB;
                            sda_low <= ~tx_shift[15];
                        end
                    end
                    ST_ACK2: begin
                        if (sck_rise && sda_s2)
                            state <= ST_IDLE;
                        else if (sck_fall) begin
                            state    <= ST_TX_CRC;
                            tx_shift <= {crc_rev, 8'h00};
                            sda_low  <= ~crc_rev[7];
                        end
                    end
                    ST_ACK3: begin
                        if (sck_rise) state <= ST_IDLE;
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

    assign SDA = (sda_low && !reset) ? 1'b0 : 1'bz;

endmodule
